// File: rtl/thresh_preset_cfg_sequencer.sv
// Sequences the ADXL362 activity/inactivity register writes for a newly selected preset.
// Optional macro THRESH_CFG_CLAMP_EN saturates the threshold at 11'h7FF instead of truncating.
module thresh_preset_cfg_sequencer #(
  parameter logic [7:0]  parm_pwr_ctl_standby = 8'h00,
  parameter logic [7:0]  parm_pwr_ctl_measure = 8'h0A,
  parameter int unsigned parm_settle_cycles   = 20000
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz_n,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  input  logic        i_cfg_req,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [7:0]  o_cmd_addr,
  output logic [7:0]  o_cmd_data,
  output logic        o_busy,
  output logic        o_cfg_done,
  output logic [3:0]  o_applied_enum
);

  localparam int unsigned CW = (parm_settle_cycles > 1) ? $clog2(parm_settle_cycles) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(parm_settle_cycles - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_WRITE, ST_SETTLE, ST_DONE} state_t;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_enum;
  logic [10:0]   r_t;
  logic [15:0]   r_timer;
  logic          r_pwrup;
  logic          r_req_hold;
  logic          r_valid;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_cfg_done;
  logic [3:0]    r_applied;
  logic [10:0]   w_t;
  logic          w_pending;

`ifdef THRESH_CFG_CLAMP_EN
  assign w_t = (i_value_thresh > 16'h07FF) ? 11'h7FF : i_value_thresh[10:0];
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^i_value_thresh[15:11];
  assign w_t = i_value_thresh[10:0];
`endif

  // Write list: {address, data} for each step of the sequence.
  function automatic logic [15:0] f_entry(input logic [2:0] idx, input logic [10:0] t,
                                          input logic [15:0] tm);
    case (idx)
      3'd0:    f_entry = {8'h2D, parm_pwr_ctl_standby};
      3'd1:    f_entry = {8'h20, t[7:0]};
      3'd2:    f_entry = {8'h21, 5'b00000, t[10:8]};
      3'd3:    f_entry = {8'h23, t[7:0]};
      3'd4:    f_entry = {8'h24, 5'b00000, t[10:8]};
      3'd5:    f_entry = {8'h25, tm[7:0]};
      3'd6:    f_entry = {8'h26, tm[15:8]};
      default: f_entry = {8'h2D, parm_pwr_ctl_measure};
    endcase
  endfunction

  assign w_pending = (i_value_enum != r_applied) || i_cfg_req || r_req_hold || r_pwrup;

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= '0;
      r_enum     <= 4'd0;
      r_t        <= 11'd0;
      r_timer    <= 16'd0;
      r_pwrup    <= 1'b1;
      r_req_hold <= 1'b0;
      r_valid    <= 1'b0;
      r_addr     <= 8'd0;
      r_data     <= 8'd0;
      r_busy     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_applied  <= 4'd0;
    end else begin
      r_cfg_done <= 1'b0;
      // Lags the state by one clock so busy stays up through the done pulse.
      r_busy     <= (r_state != ST_IDLE);
      if (i_cfg_req && (r_state != ST_IDLE)) begin
        r_req_hold <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_enum     <= i_value_enum;
          r_t        <= w_t;
          r_timer    <= i_value_timer;
          r_idx      <= 3'd0;
          r_pwrup    <= 1'b0;
          r_req_hold <= i_cfg_req;
          r_valid    <= 1'b1;
          {r_addr, r_data} <= f_entry(3'd0, w_t, i_value_timer);
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (r_valid && i_cmd_ready) begin
            if (r_idx == 3'd7) begin
              r_valid <= 1'b0;
              r_cnt   <= SETTLE_LOAD;
              r_state <= ST_SETTLE;
            end else begin
              r_idx <= r_idx + 3'd1;
              {r_addr, r_data} <= f_entry(r_idx + 3'd1, r_t, r_timer);
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_applied  <= r_enum;
          r_cfg_done <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_valid    = r_valid;
  assign o_cmd_addr     = r_addr;
  assign o_cmd_data     = r_data;
  assign o_busy         = r_busy;
  assign o_cfg_done     = r_cfg_done;
  assign o_applied_enum = r_applied;

endmodule

// File: tb/tb_thresh_preset_cfg_sequencer.sv
// Directed, table-driven bench for thresh_preset_cfg_sequencer with a short settle interval.
module tb_thresh_preset_cfg_sequencer;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_enum;
  logic [15:0] i_thresh;
  logic [15:0] i_timer;
  logic        i_req;
  logic        i_ready;
  logic        o_valid;
  logic [7:0]  o_addr;
  logic [7:0]  o_data;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_applied;

  thresh_preset_cfg_sequencer #(
    .parm_pwr_ctl_standby(8'h00),
    .parm_pwr_ctl_measure(8'h0A),
    .parm_settle_cycles(SETTLE)
  ) dut (
    .i_clk_20mhz(clk),
    .i_rst_20mhz_n(rst_n),
    .i_value_enum(i_enum),
    .i_value_thresh(i_thresh),
    .i_value_timer(i_timer),
    .i_cfg_req(i_req),
    .o_cmd_valid(o_valid),
    .i_cmd_ready(i_ready),
    .o_cmd_addr(o_addr),
    .o_cmd_data(o_data),
    .o_busy(o_busy),
    .o_cfg_done(o_done),
    .o_applied_enum(o_applied)
  );

  always #25 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [15:0] th;
    logic [15:0] tm;
    logic [7:0]  t_lo;
    logic [7:0]  t_hi;
    logic [7:0]  tm_lo;
    logic [7:0]  tm_hi;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] wq[$];
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Accepted-write log and done-pulse counter.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) wq.push_back({o_addr, o_data});
    if (o_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Offered commands must stay put until accepted.
  logic        pv, pr;
  logic [15:0] pd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= 1'b0;
      pr <= 1'b0;
      pd <= 16'h0000;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, o_valid}, 32'd1);
        chk("hold_addr_data", {16'd0, o_addr, o_data}, {16'd0, pd});
      end
      pv <= o_valid;
      pr <= i_ready;
      pd <= {o_addr, o_data};
    end
  end

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_done !== 1'b1 && n < 300);
    chk({nm, "_done_timeout"}, {31'd0, (n < 300)}, 32'd1);
  endtask

  task automatic wait_writes(input string nm, input int cnt);
    int n = 0;
    while (wq.size() < cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_write_timeout"}, {31'd0, (n < 100)}, 32'd1);
  endtask

  task automatic check_writes(input string nm, input vec_t v);
    logic [7:0] ea[8];
    logic [7:0] ed[8];
    ea = '{8'h2D, 8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h2D};
    ed = '{8'h00, v.t_lo, v.t_hi, v.t_lo, v.t_hi, v.tm_lo, v.tm_hi, 8'h0A};
    chk({nm, "_write_count"}, wq.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wq.size()) chk($sformatf("%s_write%0d", nm, i), {16'd0, wq[i]}, {16'd0, ea[i], ed[i]});
    end
  endtask

  task automatic set_in(input logic [3:0] en, input logic [15:0] th, input logic [15:0] tm);
    i_enum = en;
    i_thresh = th;
    i_timer = tm;
  endtask

  initial begin
    vec_t v;
    int base;
    vecs[0] = '{4'd0,  16'h0150, 16'h0258, 8'h50, 8'h01, 8'h58, 8'h02};
    vecs[1] = '{4'd1,  16'h07FF, 16'hFFFF, 8'hFF, 8'h07, 8'hFF, 8'hFF};
`ifdef THRESH_CFG_CLAMP_EN
    vecs[2] = '{4'd3,  16'h0900, 16'h1234, 8'hFF, 8'h07, 8'h34, 8'h12};
    vecs[4] = '{4'd5,  16'h8123, 16'hABCD, 8'hFF, 8'h07, 8'hCD, 8'hAB};
`else
    vecs[2] = '{4'd3,  16'h0900, 16'h1234, 8'h00, 8'h01, 8'h34, 8'h12};
    vecs[4] = '{4'd5,  16'h8123, 16'hABCD, 8'h23, 8'h01, 8'hCD, 8'hAB};
`endif
    vecs[3] = '{4'd15, 16'h0000, 16'h0001, 8'h00, 8'h00, 8'h01, 8'h00};

    rst_n = 1'b0;
    i_ready = 1'b1;
    i_req = 1'b0;
    set_in(vecs[0].en, vecs[0].th, vecs[0].tm);
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_addr", {24'd0, o_addr}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_applied", {28'd0, o_applied}, 32'd0);
    wq.delete();
    rst_n = 1'b1;

    // Table: power-up sequence first, then one preset change per entry.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        wq.delete();
        set_in(vecs[i].en, vecs[i].th, vecs[i].tm);
      end
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_applied", i), {28'd0, o_applied}, {28'd0, vecs[i].en});
      check_writes($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, o_done}, 32'd0);
      chk($sformatf("vec%0d_idle", i), {31'd0, o_busy}, 32'd0);
    end

    // Latency from pending detection to valid, final write and done pulse.
    @(negedge clk);
    wq.delete();
    set_in(4'd6, 16'h0042, 16'h0010);
    for (int k = 1; k <= 12 + SETTLE; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("lat_k1_busy", {31'd0, o_busy}, 32'd0);
        chk("lat_k1_valid", {31'd0, o_valid}, 32'd0);
      end
      if (k == 2) begin
        chk("lat_k2_busy", {31'd0, o_busy}, 32'd1);
        chk("lat_k2_valid", {31'd0, o_valid}, 32'd1);
        chk("lat_k2_entry0", {16'd0, o_addr, o_data}, 32'h00002D00);
      end
      if (k == 10) begin
        chk("lat_k10_valid", {31'd0, o_valid}, 32'd0);
        chk("lat_k10_writes", wq.size(), 32'd8);
      end
      if (k == 10 + SETTLE) chk("lat_pre_done", {31'd0, o_done}, 32'd0);
      if (k == 11 + SETTLE) begin
        chk("lat_done", {31'd0, o_done}, 32'd1);
        chk("lat_done_busy", {31'd0, o_busy}, 32'd1);
        chk("lat_applied", {28'd0, o_applied}, 32'd6);
      end
      if (k == 12 + SETTLE) begin
        chk("lat_post_done", {31'd0, o_done}, 32'd0);
        chk("lat_post_busy", {31'd0, o_busy}, 32'd0);
      end
    end

    // Ready withheld for five cycles on entry 3.
    @(negedge clk);
    wq.delete();
    set_in(4'd2, 16'h0123, 16'h0456);
    wait_writes("stall", 3);
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_entry3", {16'd0, o_addr, o_data}, 32'h00002323);
      chk("stall_no_advance", wq.size(), 32'd3);
    end
    i_ready = 1'b1;
    wait_done("stall");
    v = '{4'd2, 16'h0123, 16'h0456, 8'h23, 8'h01, 8'h56, 8'h04};
    check_writes("stall", v);
    chk("stall_applied", {28'd0, o_applied}, 32'd2);

    // Preset changes while settling: first completion reports the snapshot.
    @(negedge clk);
    wq.delete();
    set_in(4'd1, 16'h0200, 16'h0300);
    wait_writes("settle_chg", 8);
    set_in(4'd2, 16'h0321, 16'h0654);
    wait_done("settle_chg1");
    chk("settle_chg1_applied", {28'd0, o_applied}, 32'd1);
    v = '{4'd1, 16'h0200, 16'h0300, 8'h00, 8'h02, 8'h00, 8'h03};
    check_writes("settle_chg1", v);
    wq.delete();
    wait_done("settle_chg2");
    chk("settle_chg2_applied", {28'd0, o_applied}, 32'd2);
    v = '{4'd2, 16'h0321, 16'h0654, 8'h21, 8'h03, 8'h54, 8'h06};
    check_writes("settle_chg2", v);

    // Reset after entry 4 is accepted, then power-up rerun.
    @(negedge clk);
    wq.delete();
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    wait_writes("midrst", 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_addr_data", {16'd0, o_addr, o_data}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_applied", {28'd0, o_applied}, 32'd0);
    @(negedge clk);
    wq.delete();
    rst_n = 1'b1;
    wait_done("midrst");
    check_writes("midrst", v);
    chk("midrst_applied_after", {28'd0, o_applied}, 32'd2);

    // One idle request plus two coalesced busy requests.
    @(negedge clk);
    base = done_cnt;
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    repeat (150) @(negedge clk);
    chk("req_sequences", done_cnt - base, 32'd2);
    chk("req_idle", {31'd0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
